// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: upstream offer (sel/din/flush) and downstream result.
// The block itself takes the slave view; the driving stage takes the master view.
interface mux_n_pipe_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] din;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        dout;
    logic [SEL_W-1:0]        out_sel;
    logic                    sel_err;
    logic [7:0]              err_cnt;

    modport master (
        output in_valid, sel, din, flush, out_ready,
        input  in_ready, out_valid, dout, out_sel, sel_err, err_cnt
    );

    modport slave (
        input  in_valid, sel, din, flush, out_ready,
        output in_ready, out_valid, dout, out_sel, sel_err, err_cnt
    );
endinterface

// File: rtl/mux_n_pipe.sv
// N:1 source selector with a registered valid/ready output stage and a 2-entry skid buffer.
// Out-of-range selects emit DEFAULT_VAL, flag sel_err and bump a saturating error counter.
module mux_n_pipe #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      NUM_IN      = 4,
    parameter int unsigned      SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input logic         clk,
    input logic         rst,
    mux_n_pipe_if.slave bus
);
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;
    logic             main_err_q, main_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic             skid_err_q, skid_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] new_data;
    logic             new_err;
    logic             accept;
    logic             emit;

    always_comb begin
        new_data = DEFAULT_VAL;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (32'(bus.sel) == k) begin
                new_data = bus.din[k*WIDTH +: WIDTH];
            end
        end
    end

    assign new_err = (32'(bus.sel) >= NUM_IN);

    // Handshake decoded from registered state only; no path from out_ready to in_ready.
    assign bus.in_ready  = (state_q != StFull);
    assign bus.out_valid = (state_q != StEmpty);
    assign accept        = bus.in_valid && bus.in_ready;
    assign emit          = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;
        err_cnt_d   = err_cnt_q;

        if (bus.flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_data_d = new_data;
                        main_sel_d  = bus.sel;
                        main_err_d  = new_err;
                        state_d     = StOne;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        main_data_d = new_data;
                        main_sel_d  = bus.sel;
                        main_err_d  = new_err;
                    end else if (accept) begin
                        skid_data_d = new_data;
                        skid_sel_d  = bus.sel;
                        skid_err_d  = new_err;
                        state_d     = StFull;
                    end else if (emit) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (emit) begin
                        main_data_d = skid_data_q;
                        main_sel_d  = skid_sel_q;
                        main_err_d  = skid_err_q;
                        state_d     = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase

            if (accept && new_err && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.dout    = main_data_q;
    assign bus.out_sel = main_sel_q;
    assign bus.sel_err = main_err_q;
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: a 4-input instance with default value 0 and a 3-input
// instance with DEFAULT_VAL 0xDEADBEEF, followed by a random handshake run on the 4-input one.
module tb_mux_n_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux_n_pipe_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) a4 ();
    mux_n_pipe_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) a3 ();

    mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(32'h0)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (a4)
    );

    mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(32'hDEAD_BEEF)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (a3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout waiting for bench to complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]   q[$];
        logic [127:0]  rdin;
        logic [1:0]    rsel;
        logic [31:0]   exp_word;
        int            n;
        int            cnt;
        logic          acc;
        logic          emt;

        a4.in_valid = 0; a4.sel = '0; a4.din = '0; a4.flush = 0; a4.out_ready = 0;
        a3.in_valid = 0; a3.sel = '0; a3.din = '0; a3.flush = 0; a3.out_ready = 0;
        tick();
        tick();
        rst = 0;

        // Reset state
        chk("rst4_out_valid", a4.out_valid, 0);
        chk("rst4_in_ready", a4.in_ready, 1);
        chk("rst4_dout", a4.dout, 0);
        chk("rst4_err_cnt", a4.err_cnt, 0);
        chk("rst3_out_valid", a3.out_valid, 0);
        chk("rst3_sel_err", a3.sel_err, 0);

        // Stream through all four sources with out_ready held
        a4.din = {32'h44, 32'h33, 32'h22, 32'h11};
        a4.out_ready = 1;
        a4.in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a4.sel = 2'(i);
            chk("stream_in_ready_pre", a4.in_ready, 1);
            tick();
            chk("stream_dout", a4.dout, 128'(32'h11 * (i + 1)));
            chk("stream_out_sel", a4.out_sel, 128'(i));
            chk("stream_out_valid", a4.out_valid, 1);
            chk("stream_sel_err", a4.sel_err, 0);
        end
        a4.in_valid = 0;
        tick();
        chk("stream_drain_valid", a4.out_valid, 0);
        chk("stream_hold_dout", a4.dout, 32'h44);

        // Backpressure: A, B fill both entries, C is refused
        a4.out_ready = 0;
        a4.sel = 2'd0;
        a4.in_valid = 1;
        a4.din[31:0] = 32'hAAAA_0000;
        tick();
        chk("bp_one_ready", a4.in_ready, 1);
        chk("bp_one_dout", a4.dout, 32'hAAAA_0000);
        a4.din[31:0] = 32'hBBBB_0000;
        tick();
        chk("bp_full_ready", a4.in_ready, 0);
        chk("bp_full_dout", a4.dout, 32'hAAAA_0000);
        a4.din[31:0] = 32'hCCCC_0000;
        tick();
        chk("bp_c_refused_ready", a4.in_ready, 0);
        chk("bp_c_refused_dout", a4.dout, 32'hAAAA_0000);
        a4.in_valid = 0;
        a4.out_ready = 1;
        tick();
        chk("bp_release_dout_b", a4.dout, 32'hBBBB_0000);
        chk("bp_release_ready", a4.in_ready, 1);
        chk("bp_release_valid", a4.out_valid, 1);
        tick();
        chk("bp_drained_valid", a4.out_valid, 0);
        chk("bp_drained_dout", a4.dout, 32'hBBBB_0000);

        // Out-of-range on the 3-input instance
        a3.din = {32'h102, 32'h101, 32'h100};
        a3.out_ready = 1;
        a3.in_valid = 1;
        a3.sel = 2'd3;
        tick();
        chk("oor_dout", a3.dout, 32'hDEAD_BEEF);
        chk("oor_sel_err", a3.sel_err, 1);
        chk("oor_out_sel", a3.out_sel, 3);
        chk("oor_err_cnt", a3.err_cnt, 1);
        a3.sel = 2'd2;
        tick();
        chk("inr_dout", a3.dout, 32'h102);
        chk("inr_sel_err", a3.sel_err, 0);
        chk("inr_err_cnt", a3.err_cnt, 1);
        a3.sel = 2'd3;
        n = 1;
        for (int i = 0; i < 299; i++) begin
            tick();
            n++;
            if (n == 254) chk("sat_254", a3.err_cnt, 254);
            if (n == 255) chk("sat_255", a3.err_cnt, 255);
        end
        chk("sat_300", a3.err_cnt, 255);
        a3.in_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("rst_clears_cnt", a3.err_cnt, 0);

        // Build err_cnt=5, fill to FULL, then flush with a simultaneous bad-select offer
        a3.in_valid = 1;
        a3.sel = 2'd3;
        for (int i = 0; i < 5; i++) tick();
        chk("cnt5", a3.err_cnt, 5);
        a3.out_ready = 0;
        a3.sel = 2'd0;
        tick();
        chk("fl_full_ready", a3.in_ready, 0);
        chk("fl_full_dout", a3.dout, 32'hDEAD_BEEF);
        a3.flush = 1;
        a3.sel = 2'd3;
        tick();
        a3.flush = 0;
        a3.in_valid = 0;
        chk("fl_out_valid", a3.out_valid, 0);
        chk("fl_in_ready", a3.in_ready, 1);
        chk("fl_dout_hold", a3.dout, 32'hDEAD_BEEF);
        chk("fl_sel_err_hold", a3.sel_err, 1);
        chk("fl_err_cnt", a3.err_cnt, 5);
        a3.out_ready = 1;
        tick();
        chk("fl_nothing_after", a3.out_valid, 0);

        // Reset while FULL with err_cnt=5 and an input on offer
        a3.out_ready = 0;
        a3.in_valid = 1;
        a3.sel = 2'd1;
        tick();
        a3.sel = 2'd2;
        tick();
        chk("rf_full_ready", a3.in_ready, 0);
        chk("rf_full_dout", a3.dout, 32'h101);
        rst = 1;
        a3.sel = 2'd3;
        tick();
        rst = 0;
        a3.in_valid = 0;
        chk("rf_out_valid", a3.out_valid, 0);
        chk("rf_dout", a3.dout, 0);
        chk("rf_out_sel", a3.out_sel, 0);
        chk("rf_sel_err", a3.sel_err, 0);
        chk("rf_err_cnt", a3.err_cnt, 0);
        chk("rf_in_ready", a3.in_ready, 1);
        tick();
        chk("rf_still_empty", a3.out_valid, 0);

        // Random valid/ready against an occupancy/FIFO model
        a4.in_valid = 0;
        a4.out_ready = 0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            cnt = q.size();
            chk("rnd_out_valid", a4.out_valid, (cnt > 0) ? 1 : 0);
            chk("rnd_in_ready", a4.in_ready, (cnt < 2) ? 1 : 0);
            if (cnt > 0) chk("rnd_dout", a4.dout, q[0]);
            for (int k = 0; k < 4; k++) rdin[k*32 +: 32] = $urandom;
            rsel = 2'($urandom_range(0, 3));
            a4.din = rdin;
            a4.sel = rsel;
            a4.in_valid = ($urandom_range(0, 99) < 60);
            a4.out_ready = ($urandom_range(0, 99) < 55);
            acc = a4.in_valid && (cnt < 2);
            emt = a4.out_ready && (cnt > 0);
            exp_word = rdin[rsel*32 +: 32];
            if (emt) void'(q.pop_front());
            if (acc) q.push_back(exp_word);
            tick();
        end
        a4.in_valid = 0;
        a4.out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            if (q.size() > 0) begin
                chk("drain_dout", a4.dout, q[0]);
                void'(q.pop_front());
            end
            tick();
        end
        chk("drain_empty", a4.out_valid, 0);
        chk("rnd_err_cnt", a4.err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
